hazard_stall_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RISC-V core.
- Detects load-use hazards in ID.
- Freezes the pipeline while the data memory is not ready.
- Flushes the wrong-path fetch on a taken branch.
- Drives the bubble-select input of the ID-stage control mux, the PC/IF-ID write enables and a global pipe enable.

---
 rtl/hazard_stall_ctrl_if.sv | 35 +++
 rtl/hazard_stall_ctrl.sv | 75 +++++++
 tb/tb_hazard_stall_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline-side hazard inputs and stall/flush controls
interface hazard_stall_ctrl_if #(
    parameter int unsigned PERF_W = 16
);
    logic              idex_memread_i;
    logic [4:0]        idex_rd_i;
    logic [4:0]        ifid_rs1_i;
    logic [4:0]        ifid_rs2_i;
    logic              ifid_uses_rs2_i;
    logic              branch_taken_i;
    logic              dmem_req_i;
    logic              dmem_ready_i;
    logic              pc_write_o;
    logic              ifid_write_o;
    logic              hazard_o;
    logic              ifid_flush_o;
    logic              pipe_en_o;
    logic              timeout_err_o;
    logic [PERF_W-1:0] stall_cyc_o;
    logic [PERF_W-1:0] flush_cnt_o;

    modport master (
        output idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i, ifid_uses_rs2_i,
               branch_taken_i, dmem_req_i, dmem_ready_i,
        input  pc_write_o, ifid_write_o, hazard_o, ifid_flush_o, pipe_en_o,
               timeout_err_o, stall_cyc_o, flush_cnt_o
    );

    modport slave (
        input  idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i, ifid_uses_rs2_i,
               branch_taken_i, dmem_req_i, dmem_ready_i,
        output pc_write_o, ifid_write_o, hazard_o, ifid_flush_o, pipe_en_o,
               timeout_err_o, stall_cyc_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use bubble, memory freeze and branch flush control; HAZARD_PERF_CNT_EN adds stall/flush counters
module hazard_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned PERF_W      = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic {RUN, MWAIT} state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       lu, mw, run_ok, freeze, flush, bubble, hold_front;

    // hazard terms and Mealy outputs; reset forces the idle pattern
    always_comb begin
        lu         = bus.idex_memread_i & (bus.idex_rd_i != 5'd0) &
                     ((bus.idex_rd_i == bus.ifid_rs1_i) |
                      (bus.ifid_uses_rs2_i & (bus.idex_rd_i == bus.ifid_rs2_i)));
        mw         = bus.dmem_req_i & ~bus.dmem_ready_i;
        run_ok     = ~rst_i & (state == RUN) & ~mw;
        freeze     = ~rst_i & ((state == MWAIT) ? ~bus.dmem_ready_i : mw);
        flush      = run_ok & bus.branch_taken_i;
        bubble     = run_ok & ~bus.branch_taken_i & lu;
        hold_front = freeze | bubble;
    end

    assign bus.pc_write_o   = ~hold_front;
    assign bus.ifid_write_o = ~hold_front;
    assign bus.hazard_o     = flush | bubble;
    assign bus.ifid_flush_o = flush;
    assign bus.pipe_en_o    = ~freeze;

    // memory-wait FSM with saturating wait counter and sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= RUN;
            wait_cnt          <= 8'd0;
            bus.timeout_err_o <= 1'b0;
        end else if (state == RUN) begin
            state    <= mw ? MWAIT : RUN;
            wait_cnt <= mw ? 8'd1 : 8'd0;
        end else if (bus.dmem_ready_i) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= (&wait_cnt) ? wait_cnt : wait_cnt + 8'd1;
            if (wait_cnt >= TIMEOUT) bus.timeout_err_o <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cyc, flush_cnt;

    // saturating counts of front-end stall cycles and flush cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cyc <= '0;
            flush_cnt <= '0;
        end else begin
            if (hold_front && !(&stall_cyc)) stall_cyc <= stall_cyc + PERF_W'(1);
            if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end

    assign bus.stall_cyc_o = stall_cyc;
    assign bus.flush_cnt_o = flush_cnt;
`else
    assign bus.stall_cyc_o = {PERF_W{1'b0}};
    assign bus.flush_cnt_o = {PERF_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed plus random checks against a behavioural model
module tb_hazard_stall_ctrl;
    localparam int TO = 4;
    localparam int PW = 16;

    logic clk, rst;
    int   checks = 0;
    int   fails  = 0;

    bit   m_wait, m_err;
    int   m_run, m_stall, m_flush;

    hazard_stall_ctrl_if #(.PERF_W(PW)) bus();
    hazard_stall_ctrl #(.MEM_TIMEOUT(TO), .PERF_W(PW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // expected {pc_write, ifid_write, hazard, flush, pipe_en} from the rules
    function automatic logic [4:0] expect_out();
        bit lu;
        lu = bus.idex_memread_i && bus.idex_rd_i != 0 &&
             (bus.idex_rd_i == bus.ifid_rs1_i ||
              (bus.ifid_uses_rs2_i && bus.idex_rd_i == bus.ifid_rs2_i));
        if (rst) return 5'b11001;
        if (m_wait) return bus.dmem_ready_i ? 5'b11001 : 5'b00000;
        if (bus.dmem_req_i && !bus.dmem_ready_i) return 5'b00000;
        if (bus.branch_taken_i) return 5'b11111;
        if (lu) return 5'b00101;
        return 5'b11001;
    endfunction

    // model state advance: count consecutive frozen cycles, error past the limit
    always @(posedge clk) begin
        logic [4:0] e;
        bit frozen;
        if (rst) begin
            m_wait = 0; m_err = 0; m_run = 0; m_stall = 0; m_flush = 0;
        end else begin
            e = expect_out();
            if (!e[4] && m_stall < (1 << PW) - 1) m_stall++;
            if (e[1] && m_flush < (1 << PW) - 1) m_flush++;
            frozen = !bus.dmem_ready_i && (m_wait || bus.dmem_req_i);
            if (m_wait && frozen && m_run + 1 > TO) m_err = 1;
            m_run  = frozen ? m_run + 1 : 0;
            m_wait = frozen;
        end
    end

    // compare every cycle on the falling edge
    always @(negedge clk) begin
        logic [4:0] e;
        e = expect_out();
        chk("pc_write", bus.pc_write_o, e[4]);
        chk("ifid_write", bus.ifid_write_o, e[3]);
        chk("hazard", bus.hazard_o, e[2]);
        chk("ifid_flush", bus.ifid_flush_o, e[1]);
        chk("pipe_en", bus.pipe_en_o, e[0]);
        chk("timeout_err", bus.timeout_err_o, m_err);
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cyc", bus.stall_cyc_o, m_stall);
        chk("flush_cnt", bus.flush_cnt_o, m_flush);
`else
        chk("stall_cyc", bus.stall_cyc_o, 0);
        chk("flush_cnt", bus.flush_cnt_o, 0);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit mr, input int rd, input int rs1, input int rs2,
                         input bit u2, input bit br, input bit req, input bit rdy);
        bus.idex_memread_i  = mr;
        bus.idex_rd_i       = 5'(rd);
        bus.ifid_rs1_i      = 5'(rs1);
        bus.ifid_rs2_i      = 5'(rs2);
        bus.ifid_uses_rs2_i = u2;
        bus.branch_taken_i  = br;
        bus.dmem_req_i      = req;
        bus.dmem_ready_i    = rdy;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 5, 5, 5, 1, 1, 1, 0);
        #3;
        chk("rst_pc_write", bus.pc_write_o, 1);
        chk("rst_pipe_en", bus.pipe_en_o, 1);
        chk("rst_hazard", bus.hazard_o, 0);
        chk("rst_flush", bus.ifid_flush_o, 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        #3;
        chk("after_rst_err", bus.timeout_err_o, 0);
        tick();
        drive(1, 5, 5, 0, 0, 0, 0, 1);
        #3;
        chk("lu_hazard", bus.hazard_o, 1);
        chk("lu_pc_write", bus.pc_write_o, 0);
        chk("lu_ifid_write", bus.ifid_write_o, 0);
        chk("lu_pipe_en", bus.pipe_en_o, 1);
        tick();
        drive(0, 5, 5, 0, 0, 0, 0, 1);
        #3;
        chk("lu_next_idle", {bus.hazard_o, bus.pc_write_o}, 2'b01);
        tick();
        drive(1, 5, 3, 5, 0, 0, 0, 1);
        #3;
        chk("rs2_unused", bus.hazard_o, 0);
        tick();
        drive(1, 5, 3, 5, 1, 0, 0, 1);
        #3;
        chk("rs2_used", bus.hazard_o, 1);
        tick();
        drive(1, 0, 0, 0, 1, 0, 0, 1);
        #3;
        chk("rd_x0", bus.hazard_o, 0);
        tick();
        drive(1, 5, 5, 0, 0, 1, 0, 1);
        #3;
        chk("br_lu", {bus.ifid_flush_o, bus.hazard_o, bus.pc_write_o}, 3'b111);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        #3;
        chk("req_ready_nostall", bus.pipe_en_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            #3;
            chk("mwait_pipe_en", bus.pipe_en_o, 0);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        #3;
        chk("release", {bus.pipe_en_o, bus.pc_write_o, bus.ifid_write_o}, 3'b111);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("back_in_run", bus.pipe_en_o, 1);
        chk("short_no_err", bus.timeout_err_o, 0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            #3;
            chk("timeout_ramp", bus.timeout_err_o, (i >= 6) ? 1 : 0);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        #3;
        chk("err_sticky_release", bus.timeout_err_o, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        #3;
        chk("err_sticky_run", bus.timeout_err_o, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            drive(0, 0, 0, 0, 0, 0, 1, 0);
        end
        tick();
        rst = 1'b1;
        #3;
        chk("rst_in_mwait", {bus.pc_write_o, bus.pipe_en_o}, 2'b11);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("post_rst_run", bus.pipe_en_o, 1);
        chk("post_rst_err", bus.timeout_err_o, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            drive(1, 7, 7, 0, 0, 0, 0, 1);
            tick();
            drive(0, 0, 0, 0, 0, 0, 0, 1);
        end
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        #3;
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", bus.stall_cyc_o, 2);
        chk("perf_flush", bus.flush_cnt_o, 1);
`else
        chk("perf_stall_off", bus.stall_cyc_o, 0);
        chk("perf_flush_off", bus.flush_cnt_o, 0);
`endif
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
